fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end with a prefetch buffer, placed between instruction memory and decode. It replaces the stall-frozen PC and single IF/ID register.
- Fetch runs ahead of decode up to DEPTH entries and decouples decode stalls from memory timing.
- Redirects from branch/jump resolution flush the buffer and squash in-flight memory responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fq_fifo.sv | 72 +++++++
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN_DEFAULT     : default PC / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : canonical RV32 NOP (addi x0,x0,0)
//   count_width()    : bits needed to hold an occupancy of 0..depth
package fetch_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with flush, used both for the fetched {instr,pc} entries
// and for the in-order PC shadow of outstanding requests.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write din when not full (or when full and popping)
//   pop      : discard head entry when not empty
//   flush    : empty the FIFO; overrides push and pop
//   full, empty, count : occupancy status
//   head     : oldest entry, read straight from the storage array
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              din,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count,
   output logic [WIDTH-1:0]              head
);

   localparam int CW = count_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign head  = mem[rd_ptr];

   assign do_pop  = pop && !empty && !flush;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop) && !flush;

   // Storage needs no reset: head is only consumed while count_reg > 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count_reg <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count_reg <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end with a prefetch buffer between instruction
// memory and decode. Fetch runs ahead of decode by up to DEPTH entries;
// redirects flush the buffer and squash responses already in flight.
//   clk, rst                     : clock, asynchronous active-high reset
//   imem_req, imem_addr          : fetch request (word-aligned address)
//   imem_rvalid, imem_rdata      : in-order response, >= 1 cycle after request
//   redirect_valid, redirect_pc  : flush and restart fetch at redirect_pc
//   dec_valid, dec_ready         : head-entry handshake towards decode
//   dec_instr, dec_pc, dec_pc4   : head entry fields
//   fq_count                     : occupied buffer entries
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   output logic [XLEN-1:0]        imem_addr,
   input  logic                   imem_rvalid,
   input  logic [31:0]            imem_rdata,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [31:0]            dec_instr,
   output logic [XLEN-1:0]        dec_pc,
   output logic [XLEN-1:0]        dec_pc4,
   output logic [$clog2(DEPTH):0] fq_count
);

   localparam int CW = count_width(DEPTH);

   logic [XLEN-1:0]    fetch_pc;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      drop;
   logic [CW:0]        credits_used;
   logic               issue;
   logic               accept;
   logic               pop;

   logic               q_full, q_empty;
   logic [CW-1:0]      q_count;
   logic [32+XLEN-1:0] q_head;
   logic               s_full, s_empty;
   logic [CW-1:0]      s_count;
   logic [XLEN-1:0]    s_head;

   // Every request owns a buffer slot until its entry is consumed, so the
   // buffer can never overflow. Nothing is issued while reset is held.
   assign credits_used = {1'b0, outstanding} + {1'b0, q_count};
   assign issue        = !rst && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
   assign accept       = imem_rvalid && (drop == '0) && !redirect_valid;
   assign pop          = !q_empty && dec_ready;

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect_valid) begin
         // Every response still owed after this cycle belongs to the old path.
         fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
         outstanding <= outstanding - CW'(imem_rvalid);
         drop        <= outstanding - CW'(imem_rvalid);
      end else begin
         if (issue) fetch_pc <= fetch_pc + XLEN'(4);
         outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
         if (imem_rvalid && (drop != '0)) drop <= drop - CW'(1);
      end
   end

   // PCs of live (non-squashed) requests, in issue order.
   fq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_shadow (
      .clk   (clk),
      .rst   (rst),
      .push  (issue),
      .pop   (accept),
      .flush (redirect_valid),
      .din   (fetch_pc),
      .full  (s_full),
      .empty (s_empty),
      .count (s_count),
      .head  (s_head)
   );

   fq_fifo #(.WIDTH(32+XLEN), .DEPTH(DEPTH)) u_entries (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({imem_rdata, s_head}),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count),
      .head  (q_head)
   );

   // Head fields are forced to zero while the buffer is empty.
   assign dec_valid = !q_empty;
   assign dec_instr = dec_valid ? q_head[XLEN +: 32] : '0;
   assign dec_pc    = dec_valid ? q_head[XLEN-1:0] : '0;
   assign dec_pc4   = dec_valid ? (q_head[XLEN-1:0] + XLEN'(4)) : '0;
   assign fq_count  = q_count;

   a_drop_le_out:  assert property (@(posedge clk) disable iff (rst) drop <= outstanding);
   a_out_le_depth: assert property (@(posedge clk) disable iff (rst) outstanding <= CW'(DEPTH));
   a_credits:      assert property (@(posedge clk) disable iff (rst) credits_used <= (CW+1)'(DEPTH));
   a_shadow_sync:  assert property (@(posedge clk) disable iff (rst) s_count == outstanding - drop);
   a_no_overflow:  assert property (@(posedge clk) disable iff (rst) accept |-> (!q_full || pop));
   a_shadow_room:  assert property (@(posedge clk) disable iff (rst) issue |-> !s_full);
   a_shadow_live:  assert property (@(posedge clk) disable iff (rst) accept |-> !s_empty);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a latency-configurable in-order memory
// model, a reference model of credits/drop/occupancy, and a scoreboard of
// expected {pc, instr} entries pushed at request time and popped on decode.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_pc4;
   logic [2:0]  fq_count;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_pc4        (dec_pc4),
      .fq_count       (fq_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int ready; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t       mem_q[$];
   exp_t        sb[$];
   logic [31:0] popped_pc[$];
   logic [31:0] popped_instr[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_ready, lat_min, lat_max;
   int m_out, m_drop, m_cnt;
   logic [31:0] m_pc;

   // Per-cycle samples taken mid-cycle (negedge).
   logic        s_req, s_valid, s_rv;
   logic [31:0] s_addr;
   logic [2:0]  s_cnt;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic clear_model();
      mem_q.delete();
      sb.delete();
      popped_pc.delete();
      popped_instr.delete();
      m_out = 0; m_drop = 0; m_cnt = 0; m_pc = 32'h0; last_ready = 0;
   endtask

   // Holds reset for two edges and releases it 1 time unit after a posedge.
   task automatic do_reset();
      rst = 1'b1;
      dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One clock cycle: drive inputs, sample at negedge, check against the
   // model, update memory model and scoreboard, then advance to posedge+1.
   task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
      bit   exp_req;
      bit   do_pop;
      int   r;
      exp_t e;
      cyc++;
      dec_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
      imem_rvalid = 1'b0; imem_rdata = '0;
      if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = instr_of(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      #4;
      s_req = imem_req; s_addr = imem_addr; s_valid = dec_valid;
      s_rv = imem_rvalid; s_cnt = fq_count;
      exp_req = !redir && ((m_out + m_cnt) < DEPTH);
      do_pop  = dec_valid && rdy && !redir;

      checks++;
      if (imem_req !== exp_req) begin
         failures++;
         $display("FAIL req_credit cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
      end
      checks++;
      if (fq_count !== 3'(m_cnt)) begin
         failures++;
         $display("FAIL fq_count cyc=%0d got=%0d exp=%0d", cyc, fq_count, m_cnt);
      end
      checks++;
      if (dec_valid !== (m_cnt > 0)) begin
         failures++;
         $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, dec_valid, (m_cnt > 0));
      end

      if (imem_req) begin
         checks++;
         if (imem_addr !== m_pc) begin
            failures++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
         end
         r = cyc + $urandom_range(lat_min, lat_max);
         if (r <= last_ready) r = last_ready + 1;
         last_ready = r;
         mem_q.push_back('{addr: imem_addr, ready: r});
         sb.push_back('{pc: m_pc, instr: instr_of(m_pc)});
         m_pc = m_pc + 32'd4;
      end

      if (do_pop) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL pop_unexpected cyc=%0d got_pc=%h exp=none", cyc, dec_pc);
         end else begin
            e = sb.pop_front();
            checks++;
            if (dec_pc !== e.pc) begin
               failures++;
               $display("FAIL dec_pc cyc=%0d got=%h exp=%h", cyc, dec_pc, e.pc);
            end
            checks++;
            if (dec_instr !== e.instr) begin
               failures++;
               $display("FAIL dec_instr cyc=%0d got=%h exp=%h", cyc, dec_instr, e.instr);
            end
            checks++;
            if (dec_pc4 !== e.pc + 32'd4) begin
               failures++;
               $display("FAIL dec_pc4 cyc=%0d got=%h exp=%h", cyc, dec_pc4, e.pc + 32'd4);
            end
            popped_pc.push_back(dec_pc);
            popped_instr.push_back(dec_instr);
         end
      end

      $display("cyc=%0d req=%b addr=%h rv=%b redir=%b vld=%b rdy=%b pc=%h cnt=%0d",
               cyc, imem_req, imem_addr, imem_rvalid, redir, dec_valid, rdy, dec_pc, fq_count);

      if (redir) begin
         m_out  = m_out - int'(s_rv);
         m_drop = m_out;
         m_cnt  = 0;
         sb.delete();
         m_pc   = {rpc[31:2], 2'b00};
      end else begin
         m_out = m_out + int'(imem_req) - int'(s_rv);
         if (s_rv) begin
            if (m_drop > 0) m_drop--;
            else m_cnt++;
         end
         if (do_pop) m_cnt--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      checks++;
      if ({imem_req, dec_valid, dec_instr, dec_pc, dec_pc4, fq_count} !== '0) begin
         failures++;
         $display("FAIL %s got req=%b vld=%b instr=%h pc=%h pc4=%h cnt=%0d exp=all_zero",
                  tag, imem_req, dec_valid, dec_instr, dec_pc, dec_pc4, fq_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      #3;
      check_zero_outputs("reset_state");
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (6) tick(1'b1, 1'b0, 32'h0);
      // Asynchronous reset in the middle of a cycle.
      rst = 1'b1;
      #2;
      check_zero_outputs("mid_reset");
      do_reset();
   endtask

   task automatic test_stream();
      int first_req, first_val, start;
      do_reset();
      lat_min = 1; lat_max = 1;
      first_req = -1; first_val = -1; start = cyc + 1;
      repeat (12) begin
         tick(1'b1, 1'b0, 32'h0);
         if (s_req && first_req < 0) first_req = cyc;
         if (s_valid && first_val < 0) first_val = cyc;
      end
      checks++;
      if (first_req != start) begin
         failures++;
         $display("FAIL first_req_cycle got=%0d exp=%0d", first_req, start);
      end
      checks++;
      if (first_val - first_req != 2) begin
         failures++;
         $display("FAIL req_to_valid_latency got=%0d exp=2", first_val - first_req);
      end
      checks++;
      if (popped_pc.size() < 8) begin
         failures++;
         $display("FAIL stream_throughput got=%0d exp>=8", popped_pc.size());
      end
   endtask

   task automatic test_backpressure();
      bit saw_req;
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (10) tick(1'b0, 1'b0, 32'h0);
      checks++;
      if (s_req !== 1'b0) begin
         failures++;
         $display("FAIL full_req_stall got=%b exp=0", s_req);
      end
      checks++;
      if (s_cnt !== 3'd4) begin
         failures++;
         $display("FAIL full_count got=%0d exp=4", s_cnt);
      end
      saw_req = 1'b0;
      repeat (10) begin
         tick(1'b1, 1'b0, 32'h0);
         if (s_req) saw_req = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (popped_pc.size() <= i || popped_pc[i] !== 32'(i * 4)) begin
            failures++;
            $display("FAIL drain_order idx=%0d got=%h exp=%h", i,
                     (popped_pc.size() > i) ? popped_pc[i] : 32'hx, 32'(i * 4));
         end
      end
      checks++;
      if (!saw_req) begin
         failures++;
         $display("FAIL resume_req got=0 exp=1");
      end
   endtask

   task automatic test_redirect_squash();
      bit stale;
      do_reset();
      lat_min = 3; lat_max = 3;
      repeat (2) tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 32'h100);
      repeat (15) tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (popped_pc.size() == 0 || popped_pc[0] !== 32'h100) begin
         failures++;
         $display("FAIL squash_first_pc got=%h exp=00000100",
                  (popped_pc.size() > 0) ? popped_pc[0] : 32'hx);
      end
      checks++;
      if (popped_instr.size() == 0 || popped_instr[0] !== instr_of(32'h100)) begin
         failures++;
         $display("FAIL squash_first_instr got=%h exp=%h",
                  (popped_instr.size() > 0) ? popped_instr[0] : 32'hx, instr_of(32'h100));
      end
      stale = 1'b0;
      foreach (popped_pc[i]) if (popped_pc[i] < 32'h100) stale = 1'b1;
      checks++;
      if (stale) begin
         failures++;
         $display("FAIL stale_pc got=stale_seen exp=none");
      end
   endtask

   task automatic test_redirect_collide();
      do_reset();
      lat_min = 2; lat_max = 2;
      repeat (8) tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 32'h100);
      checks++;
      if (!(s_rv && s_valid)) begin
         failures++;
         $display("FAIL collide_setup got rv=%b vld=%b exp rv=1 vld=1", s_rv, s_valid);
      end
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (s_cnt !== 3'd0 || s_valid !== 1'b0) begin
         failures++;
         $display("FAIL collide_flush got cnt=%0d vld=%b exp cnt=0 vld=0", s_cnt, s_valid);
      end
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h100) begin
         failures++;
         $display("FAIL collide_restart got req=%b addr=%h exp req=1 addr=00000100", s_req, s_addr);
      end
      repeat (10) tick(1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_align_wrap();
      tick(1'b1, 1'b1, 32'h102);
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h100) begin
         failures++;
         $display("FAIL align got req=%b addr=%h exp req=1 addr=00000100", s_req, s_addr);
      end
      tick(1'b1, 1'b1, 32'hFFFF_FFFC);
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_start got req=%b addr=%h exp req=1 addr=fffffffc", s_req, s_addr);
      end
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
         failures++;
         $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=00000000", s_req, s_addr);
      end
      repeat (10) tick(1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 800; i++) begin
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      end
      repeat (20) tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (popped_pc.size() < 100) begin
         failures++;
         $display("FAIL random_progress got=%0d exp>=100", popped_pc.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_squash();
      test_redirect_collide();
      test_align_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
